// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//
// Serial-in/parallel-out receiver for the 16-bit PISO serializer. Bits arrive
// MSB first on sin, qualified by sin_en; sin_last (the serializer's complete
// flag) marks the final bit of a word. Finished words go to a one-word
// holding register with a valid/ready output. Overrun and framing errors are
// reported as sticky status bits.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   sin          serial data, MSB first
//   sin_en       bit strobe; sin/sin_last sampled only when high
//   sin_last     final bit of a word (ignored when sin_en low)
//   pout         assembled word
//   pout_valid   pout holds an undelivered word
//   pout_ready   consumer accepts pout
//   busy         partial word held in the shift register (FSM in RECV)
//   overrun      sticky: completed word dropped because pout was occupied
//   framing_err  sticky: sin_last position disagreed with WIDTH
//   err_clr      synchronous clear of overrun and framing_err
//   word_count   words handed off, wraps modulo 2^CNT_W
//
// Handshake: a word transfers on every rising clk edge where pout_valid and
// pout_ready are both high. pout_valid is never withdrawn and pout never
// changes while pout_valid is high without a transfer; a new word may load
// on the same edge that the current one transfers.
module sipo_deserializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sin_last,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             framing_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] word_count
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;

  logic             last_pos;
  logic             complete;
  logic             early_last;
  logic             frame_evt;
  logic             handshake;
  logic             load;
  logic             drop;
  logic [WIDTH-1:0] word_next;

  // Word boundary detection. The bit counter, not sin_last, decides where a
  // word ends; sin_last only cross-checks it.
  assign last_pos   = (bit_cnt == CW'(WIDTH - 1));
  assign complete   = sin_en & last_pos;
  assign early_last = sin_en & sin_last & ~last_pos;
  assign frame_evt  = early_last | (complete & ~sin_last);
  assign word_next  = {shift_reg[WIDTH-2:0], sin};

  // The holding register can take a new word if it is empty or is being
  // emptied on this same edge.
  assign handshake  = pout_valid & pout_ready;
  assign load       = complete & (~pout_valid | handshake);
  assign drop       = complete & ~load;

  // busy is the externally visible view of the FSM state.
  assign busy = (state_q == RECV);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sin_en && !early_last && !complete) state_d = RECV;
      end
      RECV: begin
        if (complete || early_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift register and bit counter. An early sin_last simply rewinds the
  // counter; the stale partial bits are shifted out by the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sin_en) begin
      shift_reg <= word_next;
      if (complete || early_last) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Output holding register and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      word_count <= '0;
    end else begin
      if (load) begin
        pout       <= word_next;
        pout_valid <= 1'b1;
      end else if (handshake) begin
        pout_valid <= 1'b0;
      end
      if (handshake) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

  // Sticky error flags: a new error on the same edge as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (frame_evt) begin
        framing_err <= 1'b1;
      end else if (err_clr) begin
        framing_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst;
  logic             sin;
  logic             sin_en;
  logic             sin_last;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             busy;
  logic             overrun;
  logic             framing_err;
  logic             err_clr;
  logic [CNT_W-1:0] word_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .sin_en      (sin_en),
    .sin_last    (sin_last),
    .pout        (pout),
    .pout_valid  (pout_valid),
    .pout_ready  (pout_ready),
    .busy        (busy),
    .overrun     (overrun),
    .framing_err (framing_err),
    .err_clr     (err_clr),
    .word_count  (word_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && pout_valid && pout_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(pout), 32'hFFFF_FFFF);
      end else begin
        check("sb_word", 32'(pout), 32'(exp_q.pop_front()));
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b, input logic last);
    sin_en   = 1'b1;
    sin      = b;
    sin_last = last;
    @(posedge clk);
    #1;
    sin_en   = 1'b0;
    sin      = 1'b0;
    sin_last = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic mark_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i], mark_last && (i == 0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] exp_pout;
    logic [CNT_W-1:0] exp_count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [WIDTH-1:0] w;

    vecs[0] = '{word: 16'hA5C3, exp_pout: 16'hA5C3, exp_count: 8'd1};
    vecs[1] = '{word: 16'h0001, exp_pout: 16'h0001, exp_count: 8'd2};
    vecs[2] = '{word: 16'h8000, exp_pout: 16'h8000, exp_count: 8'd3};
    vecs[3] = '{word: 16'hFFFF, exp_pout: 16'hFFFF, exp_count: 8'd4};
    vecs[4] = '{word: 16'h0000, exp_pout: 16'h0000, exp_count: 8'd5};
    vecs[5] = '{word: 16'h5A5A, exp_pout: 16'h5A5A, exp_count: 8'd6};

    rst        = 1'b1;
    sin        = 1'b0;
    sin_en     = 1'b0;
    sin_last   = 1'b0;
    pout_ready = 1'b0;
    err_clr    = 1'b0;
    #1;
    check("rst_pout",  32'(pout), 0);
    check("rst_valid", 32'(pout_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ovr",   32'(overrun), 0);
    check("rst_frm",   32'(framing_err), 0);
    check("rst_count", 32'(word_count), 0);
    #11;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean words, consumer always ready: valid for one cycle per word.
    pout_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(vecs[k].word);
      send_bit(vecs[k].word[WIDTH-1], 1'b0);
      check("tbl_busy_first", 32'(busy), 1);
      for (int i = WIDTH - 2; i >= 0; i--) begin
        send_bit(vecs[k].word[i], i == 0);
      end
      check("tbl_pout",  32'(pout), 32'(vecs[k].exp_pout));
      check("tbl_valid", 32'(pout_valid), 1);
      check("tbl_busy",  32'(busy), 0);
      check("tbl_frm",   32'(framing_err), 0);
      check("tbl_ovr",   32'(overrun), 0);
      idle(1);
      check("tbl_valid_drop", 32'(pout_valid), 0);
      check("tbl_count", 32'(word_count), 32'(vecs[k].exp_count));
    end

    // Back-to-back words with stalled consumer: second word overruns.
    pout_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 1'b1);
    check("stall_pout1",  32'(pout), 32'h1234);
    check("stall_valid1", 32'(pout_valid), 1);
    check("stall_ovr1",   32'(overrun), 0);
    send_word(16'hFFFF, 1'b1);
    check("stall_pout2",  32'(pout), 32'h1234);
    check("stall_valid2", 32'(pout_valid), 1);
    check("stall_ovr2",   32'(overrun), 1);
    pout_ready = 1'b1;
    idle(1);
    check("stall_valid3", 32'(pout_valid), 0);
    check("stall_count",  32'(word_count), 7);
    check("stall_ovr3",   32'(overrun), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("stall_ovr_clr", 32'(overrun), 0);

    // Completion on the same edge as a handshake.
    pout_ready = 1'b0;
    exp_q.push_back(16'h00FF);
    send_word(16'h00FF, 1'b1);
    idle(2);
    check("sim_hold_pout",  32'(pout), 32'h00FF);
    check("sim_hold_valid", 32'(pout_valid), 1);
    w = 16'h8001;
    exp_q.push_back(w);
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(w[i], 1'b0);
    pout_ready = 1'b1;
    send_bit(w[0], 1'b1);
    check("sim_pout",  32'(pout), 32'h8001);
    check("sim_valid", 32'(pout_valid), 1);
    check("sim_ovr",   32'(overrun), 0);
    check("sim_count", 32'(word_count), 8);
    idle(1);
    check("sim_valid2", 32'(pout_valid), 0);
    check("sim_count2", 32'(word_count), 9);

    // Framing: early sin_last on bit 10, then a word with no sin_last.
    for (int i = 1; i <= 10; i++) send_bit(1'b1, i == 10);
    check("frm_early_flag",  32'(framing_err), 1);
    check("frm_early_busy",  32'(busy), 0);
    check("frm_early_valid", 32'(pout_valid), 0);
    exp_q.push_back(16'h0F0F);
    send_word(16'h0F0F, 1'b0);
    check("frm_pout",  32'(pout), 32'h0F0F);
    check("frm_valid", 32'(pout_valid), 1);
    check("frm_flag",  32'(framing_err), 1);
    idle(1);
    check("frm_count", 32'(word_count), 10);
    // New error on the same edge as err_clr keeps the flag set.
    err_clr = 1'b1;
    send_bit(1'b0, 1'b1);
    err_clr = 1'b0;
    check("frm_err_wins", 32'(framing_err), 1);
    check("frm_err_busy", 32'(busy), 0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("frm_clr", 32'(framing_err), 0);

    // Gapped strobes with random sin/sin_last during the gaps.
    w = 16'hBEEF;
    exp_q.push_back(w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i], i == 0);
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          sin      = 1'($urandom_range(0, 1));
          sin_last = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        sin      = 1'b0;
        sin_last = 1'b0;
        if (i == 8) check("gap_busy", 32'(busy), 1);
      end
    end
    check("gap_pout",  32'(pout), 32'hBEEF);
    check("gap_valid", 32'(pout_valid), 1);
    check("gap_frm",   32'(framing_err), 0);
    idle(1);
    check("gap_count", 32'(word_count), 11);

    // Reset in the middle of a word, asserted away from the clock edge.
    w = 16'h1357;
    for (int i = WIDTH - 1; i >= WIDTH - 7; i--) send_bit(w[i], 1'b0);
    check("mid_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_pout",  32'(pout), 0);
    check("mid_rst_valid", 32'(pout_valid), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_count", 32'(word_count), 0);
    check("mid_rst_ovr",   32'(overrun), 0);
    check("mid_rst_frm",   32'(framing_err), 0);
    #3;
    rst = 1'b0;
    exp_q.push_back(16'hCAFE);
    send_word(16'hCAFE, 1'b1);
    check("post_rst_pout",  32'(pout), 32'hCAFE);
    check("post_rst_valid", 32'(pout_valid), 1);
    check("post_rst_frm",   32'(framing_err), 0);
    idle(1);
    check("post_rst_count", 32'(word_count), 1);

    idle(2);
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out receiver that sits directly downstream of the team's 16-bit PISO serializer. It reassembles MSB-first serial bits into WIDTH-bit words using a bit strobe and an end-of-word marker, which is the serializer's `complete` flag. It presents each finished word on a registered valid/ready output with a one-word holding buffer. It flags overrun and framing errors as sticky status bits.

## Interface
- WIDTH, 16, word length in bits (≥2)
- CNT_W, 8, width of delivered-word counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- sin  in  1  serial data, MSB first
- sin_en  in  1  bit strobe; sin/sin_last sampled only when high
- sin_last  in  1  marks final bit of a word; ignored when sin_en low
- pout  out  WIDTH  assembled word
- pout_valid  out  1  pout holds an undelivered word
- pout_ready  in  1  consumer accepts pout when pout_valid & pout_ready
- busy  out  1  partial word in shift register (state RECV)
- overrun  out  1  sticky: completed word dropped because output buffer full
- framing_err  out  1  sticky: sin_last position disagrees with WIDTH
- err_clr  in  1  synchronous clear of overrun and framing_err
- word_count  out  CNT_W  words handed off, wraps modulo 2^CNT_W

## Operation
- Reset: shift register, bit_cnt, pout, pout_valid, busy, overrun, framing_err and word_count are all 0. State is IDLE. A partial word in progress is discarded.
- States:
  - IDLE (bit_cnt = 0)
  - RECV (0 < bit_cnt < WIDTH)
- IDLE→RECV on the first sin_en. RECV→IDLE on word completion or on an early sin_last.
- Each sin_en cycle: shift_reg ← {shift_reg[WIDTH-2:0], sin}; bit_cnt increments.
- Word completes on the sin_en cycle where bit_cnt = WIDTH-1:
  - Candidate word = {shift_reg[WIDTH-2:0], sin}.
  - bit_cnt returns to 0.
  - If sin_last was low on that bit, the word is still completed and framing_err is set.
- Early sin_last (sin_en & sin_last with bit_cnt < WIDTH-1):
  - Partial word is discarded.
  - framing_err is set.
  - bit_cnt returns to 0 and state returns to IDLE.
  - Nothing is delivered.
- Output buffer:
  - On completion, if pout_valid = 0 or a handshake occurs in the same cycle: pout ← word and pout_valid ← 1.
  - Otherwise the word is dropped, overrun is set, and pout/pout_valid are unchanged.
- Handshake (pout_valid & pout_ready): word_count increments. pout_valid clears unless a new word loads in the same cycle.
- pout is stable while pout_valid = 1 and no handshake occurs.
- err_clr clears both sticky bits. If a new error occurs in the same cycle as err_clr, the error wins and the bit stays set.
- sin_en low: no state change except output handshake and err_clr.

## Timing
- Sampling edge = rising clk edge at which sin_en = 1.
- Latency: pout/pout_valid update at the same edge that samples the final bit. pout_valid is visible in the following cycle.
- Throughput: one bit per cycle sustained. Back-to-back words need no idle gap.
- Consumer deadline: with continuous sin_en, the consumer has WIDTH cycles to take a word before the next completion causes overrun.
- pout_ready may be held high permanently. With ready always high, valid pulses for exactly 1 cycle per word.
- busy is 1 exactly while bit_cnt ≠ 0.
- Sticky flags rise in the cycle after the offending sampling edge.
- Async rst forces all outputs to 0 immediately, independent of clk.

## Test plan
- Clean word: 0xA5C3 sent MSB first, sin_en = 1 for 16 cycles, sin_last on bit 16, pout_ready = 1 → pout = 0xA5C3 with pout_valid high for 1 cycle after the 16th edge. word_count = 1. No errors.
- Back-to-back with stalled consumer: 0x1234 then 0xFFFF continuously, pout_ready = 0 → pout holds 0x1234, overrun = 1 after the 32nd edge, 0xFFFF dropped. Then pout_ready = 1 → handshake, word_count = 1. err_clr → overrun = 0.
- Simultaneous completion and handshake: pout_valid holding 0x00FF, pout_ready = 1 on the cycle 0x8001 completes → pout = 0x8001, pout_valid stays 1, overrun = 0, word_count increments.
- Framing: sin_last on bit 10 → framing_err = 1, busy = 0, nothing delivered. Next 16 bits of 0x0F0F with sin_last missing → pout = 0x0F0F delivered, framing_err remains 1.
- Gapped strobes: 0xBEEF with sin_en low for 3 random cycles between bits → pout = 0xBEEF. Bits are unaffected by sin values during gaps.
- Reset mid-word: assert rst after 7 bits of a word → all outputs 0 immediately. After release, a full 0xCAFE word decodes correctly.
